mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-input N-bit mux datapath (mux8to1).
- Eight requesters each present an N-bit word with a req line; the block picks one winner per cycle and drives the mux select.
- It captures the selected word into a registered output stage with a valid/ready handshake.
- An optional burst lock lets a winner keep the mux for up to BURST consecutive beats.

Parameters:
- N, 8, data width per requester and of out_data.
- BURST, 4, max consecutive beats granted to one owner before priority rotates; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  per-requester request; req[i] is held until gnt[i].
- data_in  in  8*N  flattened words; requester i at [i*N +: N].
- gnt  out  8  one-hot, combinational; gnt[i]=1 means the word from i is taken this edge.
- sel  out  3  combinational winner index, drives mux8to1 .s.
- out_valid  out  1  registered output word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  N  registered selected word.
- out_src  out  3  registered index of the requester that supplied out_data.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_src=0, ptr=0, owner_vld=0, owner=0, cnt=0. gnt is 0 while rst=1.
- accept = (|req) && (!out_valid || out_ready) && !rst.
- Winner w:
  - If owner_vld && req[owner], w=owner.
  - Otherwise w is the first set bit of req scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod-8 wrap).
- sel=w whenever |req. If req=0, sel holds ptr.
- gnt = accept ? onehot(w) : 0.
- Transfer on accept:
  - out_data <= data_in[w]; out_src <= w; out_valid <= 1.
  - Latency is 1 cycle from req to out_valid.
  - Throughput is 1 word/cycle while out_ready=1.
- Drain: out_valid && out_ready && !accept -> out_valid <= 0.
- Stall: out_valid && !out_ready -> out_data, out_src and out_valid hold; gnt=0; ptr, owner and cnt hold.
- Burst state update on accept:
  - Continuing owner (owner_vld && w==owner): cnt <= cnt+1. If cnt+1==BURST, then owner_vld <= 0 and ptr <= w+1.
  - New winner with BURST==1: owner_vld stays 0; ptr <= w+1.
  - New winner with BURST>1: owner_vld <= 1, owner <= w, cnt <= 1, ptr <= w+1.
- Early release: owner_vld && !req[owner] in any cycle (including stall) -> owner_vld <= 0 and cnt <= 0. The same cycle's winner comes from the rotating scan.
- ptr arithmetic is 3-bit and wraps 7 -> 0. cnt is 4-bit and never exceeds BURST.
- Simultaneous accept and drain: the new word replaces the old one, out_valid stays 1.
- rst asserted mid-burst or during a stall: all state clears at that edge and any pending out_data is dropped. Requesters must re-present.

Decomposition:
- Shared package holds:
  - NREQ=8 and SEL_W=3.
  - Burst counter width CNT_W=4.
  - Reset constants for ptr and cnt.
- Sub-module rr_pick8: combinational rotating priority encoder.
  - Inputs req[7:0] and ptr[2:0].
  - Outputs any and idx[2:0].
- The datapath reuses the existing mux8to1 #(N) instance, driven by sel. The top keeps owner/cnt/ptr and the output register.

Test Plan:
- Reset then single request: req=8'h04, data_in[2]=8'hCC, out_ready=1 -> gnt=8'h04 in the accept cycle. Next cycle out_valid=1, out_data=8'hCC, out_src=2.
- Fair rotation, BURST=1: req=8'hFF held, words 8'hA0+i, out_ready=1 -> out_src sequence is 0,1,2,...,7,0 on consecutive cycles.
- Burst lock, BURST=4: req=8'h03 held -> out_src sequence is 0,0,0,0,1,1,1,1,0. Dropping req[0] after 2 beats -> the next out_src is 1 immediately.
- Backpressure: out_ready=0 after the first word 8'hAA -> out_data stays 8'hAA, gnt=0, and ptr/cnt are unchanged for 5 cycles. With out_ready=1 the next word follows with no lost or duplicated beats.
- Wrap: last grant 7, then req=8'h81 -> winner 0 (ptr wrapped to 0), then 7.
- Mid-burst reset: assert rst after 2 of 4 owner beats -> next cycle out_valid=0, ptr=0. The first post-reset grant with req=8'h82 goes to 1.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-way round-robin mux arbiter.
// Index, counter and reset values live here so that the top and the picker agree on widths.
package mux8_rr_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef logic [SEL_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam idx_t PTR_RST = '0;
    localparam cnt_t CNT_RST = '0;

    function automatic logic [NREQ-1:0] onehot8(input idx_t i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bundle of the arbiter: request side, mux select and registered output.
interface mux8_rr_arbiter_if #(parameter int N = 8);
    logic [7:0]     req;
    logic [8*N-1:0] data_in;
    logic [7:0]     gnt;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [2:0]     out_src;

    modport master (
        output req, data_in, out_ready,
        input  gnt, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  req, data_in, out_ready,
        output gnt, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux8_rr_arbiter_pick.sv
// Rotating priority encoder: first set bit of req scanning from ptr upward with mod-8 wrap.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            ptr,
    output logic            any,
    output idx_t            idx
);
    logic [NREQ-1:0] rot;
    idx_t            off;

    // rot[k] is the request k positions after ptr, so the lowest set bit wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot[gi] = req[ptr + idx_t'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = idx_t'(k);
        end
    end

    assign any = |req;
    assign idx = ptr + off;
endmodule

// File: rtl/mux8to1.sv
// Plain 8-to-1 word multiplexer; word i of d sits at [i*N +: N].
module mux8to1 #(
    parameter int N = 8
) (
    input  logic [8*N-1:0] d,
    input  logic [2:0]     s,
    output logic [N-1:0]   y
);
    assign y = d[s*N +: N];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter with burst lock driving mux8to1, plus a registered valid/ready output stage.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);
    localparam cnt_t BURST_C = cnt_t'(BURST);

    idx_t         ptr_reg;
    idx_t         owner_reg;
    logic         owner_vld_reg;
    cnt_t         cnt_reg;
    logic         out_valid_reg;
    logic [N-1:0] out_data_reg;
    idx_t         out_src_reg;

    logic         any;
    idx_t         pick_idx;
    idx_t         win;
    logic         owner_hit;
    logic         accept;
    cnt_t         cnt_inc;
    logic [N-1:0] mux_y;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_reg),
        .any (any),
        .idx (pick_idx)
    );

    // A locked owner keeps the mux only while it is still requesting.
    assign owner_hit = owner_vld_reg && bus.req[owner_reg];
    assign win       = owner_hit ? owner_reg : pick_idx;
    assign accept    = any && (!out_valid_reg || bus.out_ready) && !rst;
    assign cnt_inc   = cnt_reg + cnt_t'(1);

    assign bus.sel = any ? win : ptr_reg;
    assign bus.gnt = accept ? onehot8(win) : '0;

    mux8to1 #(.N(N)) u_mux (
        .d (bus.data_in),
        .s (bus.sel),
        .y (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            ptr_reg       <= PTR_RST;
            owner_vld_reg <= 1'b0;
            owner_reg     <= '0;
            cnt_reg       <= CNT_RST;
        end else begin
            if (accept) begin
                out_data_reg  <= mux_y;
                out_src_reg   <= win;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            // Early release applies even while stalled; an accept below may re-lock.
            if (owner_vld_reg && !bus.req[owner_reg]) begin
                owner_vld_reg <= 1'b0;
                cnt_reg       <= CNT_RST;
            end

            if (accept) begin
                if (owner_hit) begin
                    cnt_reg <= cnt_inc;
                    if (cnt_inc == BURST_C) begin
                        owner_vld_reg <= 1'b0;
                        ptr_reg       <= win + idx_t'(1);
                    end
                end else if (BURST == 1) begin
                    ptr_reg <= win + idx_t'(1);
                end else begin
                    owner_vld_reg <= 1'b1;
                    owner_reg     <= win;
                    cnt_reg       <= cnt_t'(1);
                    ptr_reg       <= win + idx_t'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench: one arbiter with BURST=1 (rotation, wrap, backpressure) and one with BURST=4 (burst lock).
module tb_mux8_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux8_rr_arbiter_if #(.N(8)) b1 ();
    mux8_rr_arbiter_if #(.N(8)) b4 ();

    mux8_rr_arbiter #(.N(8), .BURST(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mux8_rr_arbiter #(.N(8), .BURST(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rs;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] src;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational gnt, then the registered outputs after the edge.
    task automatic step(input bit use4, input string nm, input logic rs, input logic [7:0] r,
                        input logic rdy, input logic [7:0] eg, input logic ev,
                        input logic [2:0] es, input logic [7:0] ed);
        logic [7:0] g;
        rst = rs;
        if (use4) begin
            b4.req = r; b4.out_ready = rdy; b1.req = 8'h00; b1.out_ready = 1'b1;
        end else begin
            b1.req = r; b1.out_ready = rdy; b4.req = 8'h00; b4.out_ready = 1'b1;
        end
        #1;
        g = use4 ? b4.gnt : b1.gnt;
        chk({nm, " gnt"}, 32'(g), 32'(eg));
        @(posedge clk);
        #1;
        chk({nm, " out_valid"}, 32'(use4 ? b4.out_valid : b1.out_valid), 32'(ev));
        chk({nm, " out_src"},   32'(use4 ? b4.out_src   : b1.out_src),   32'(es));
        chk({nm, " out_data"},  32'(use4 ? b4.out_data  : b1.out_data),  32'(ed));
        $display("%s: rst=%0b req=%h rdy=%0b gnt=%h valid=%0b src=%0d data=%h",
                 nm, rs, r, rdy, g,
                 use4 ? b4.out_valid : b1.out_valid,
                 use4 ? b4.out_src : b1.out_src,
                 use4 ? b4.out_data : b1.out_data);
    endtask

    initial begin
        b1.req = 8'h00; b1.out_ready = 1'b1;
        b4.req = 8'h00; b4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1.data_in[i*8 +: 8] = 8'(8'hA0 + i);
            b4.data_in[i*8 +: 8] = 8'(8'hA0 + i);
        end
        b1.data_in[2*8 +: 8] = 8'hCC;

        //            rs    req    rdy   gnt    vld   src   dat
        tbl.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00});
        tbl.push_back('{1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hCC});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 8'hCC});
        tbl.push_back('{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 8'hCC});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 8'hA4});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 8'hA6});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7});
        tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0});
        tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7});
        tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 8'hA0});
        tbl.push_back('{1'b0, 8'h02, 1'b0, 8'h00, 1'b1, 3'd0, 8'hA0});
        tbl.push_back('{1'b0, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd1, 8'hA1});

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, $sformatf("tbl%0d", i), tbl[i].rs, tbl[i].req, tbl[i].rdy,
                 tbl[i].gnt, tbl[i].vld, tbl[i].src, tbl[i].dat);
        end

        // Backpressure on BURST=1: first word AA held through 5 stalled cycles, ptr must not move.
        b1.data_in[3*8 +: 8] = 8'hAA;
        b1.data_in[4*8 +: 8] = 8'hBB;
        step(1'b0, "bp_rst", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        step(1'b0, "bp_first", 1'b0, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $sformatf("bp_stall%0d", i), 1'b0, 8'h11, 1'b0, 8'h00, 1'b1, 3'd3, 8'hAA);
        end
        chk("bp sel during stall", 32'(b1.sel), 32'd4);
        step(1'b0, "bp_resume", 1'b0, 8'h11, 1'b1, 8'h10, 1'b1, 3'd4, 8'hBB);
        step(1'b0, "bp_next", 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b0, "bp_drain", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'hA0);
        chk("idle sel holds ptr", 32'(b1.sel), 32'd1);

        // Burst lock, BURST=4: 0,0,0,0,1,1,1,1,0.
        step(1'b1, "burst_rst", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            logic [2:0] s;
            s = (i >= 4 && i < 8) ? 3'd1 : 3'd0;
            step(1'b1, $sformatf("burst%0d", i), 1'b0, 8'h03, 1'b1,
                 (s == 3'd1) ? 8'h02 : 8'h01, 1'b1, s, 8'(8'hA0 + s));
        end

        // Early release: req[0] drops after 2 beats, requester 1 wins at once.
        step(1'b1, "rel_rst", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        step(1'b1, "rel0", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "rel1", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "rel2", 1'b0, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1);

        // Stall mid-burst: cnt holds, so two more owner beats follow before rotating.
        step(1'b1, "bst_rst", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        step(1'b1, "bst0", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "bst1", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $sformatf("bst_hold%0d", i), 1'b0, 8'h03, 1'b0, 8'h00, 1'b1, 3'd0, 8'hA0);
        end
        step(1'b1, "bst2", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "bst3", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "bst4", 1'b0, 8'h03, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1);

        // Mid-burst reset: pending word dropped, first grant afterwards with req=82 goes to 1.
        step(1'b1, "mrst_pre", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        step(1'b1, "mrst0", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "mrst1", 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        step(1'b1, "mrst_rst", 1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        step(1'b1, "mrst_post", 1'b0, 8'h82, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1);
        step(1'b1, "mrst_sel", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd1, 8'hA1);
        chk("post-reset idle sel", 32'(b4.sel), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
